// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle between a single master and a single slave.
// The modports give each side its own direction for every channel.
interface axil_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one bus
// transaction and returns its response on a valid/ready response port.
module axil_master #(
  parameter int         C_M_AXI_DATA_WIDTH = 32,
  parameter int         C_M_AXI_ADDR_WIDTH = 5,
  parameter logic [2:0] C_PROT             = 3'b000
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_we,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  axil_master_if.master                   M_AXI
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

  state_t                            state;
  state_t                            state_next;
  logic                              init_done;
  logic                              we_q;
  logic                              aw_pend;
  logic                              w_pend;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q;
  logic [1:0]                        resp_q;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // init_done keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      init_done <= 1'b0;
      we_q      <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
    end else begin
      init_done <= 1'b1;
      if (cmd_valid && cmd_ready) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        we_q    <= cmd_we;
        aw_pend <= cmd_we;
        w_pend  <= cmd_we;
      end else begin
        if (aw_pend && M_AXI.AWREADY) aw_pend <= 1'b0;
        if (w_pend && M_AXI.WREADY)   w_pend  <= 1'b0;
      end
      if (state == WRESP && M_AXI.BVALID) begin
        resp_q  <= M_AXI.BRESP;
        rdata_q <= '0;
      end
      if (state == RDATA && M_AXI.RVALID) begin
        resp_q  <= M_AXI.RRESP;
        rdata_q <= M_AXI.RDATA;
      end
    end
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    rsp_valid     = 1'b0;
    M_AXI.AWVALID = 1'b0;
    M_AXI.WVALID  = 1'b0;
    M_AXI.BREADY  = 1'b0;
    M_AXI.ARVALID = 1'b0;
    M_AXI.RREADY  = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = init_done;
        if (cmd_valid && init_done) begin
          state_next = cmd_we ? WRITE : RADDR;
        end
      end
      // AW and W retire independently; leave once neither is still pending.
      WRITE: begin
        M_AXI.AWVALID = aw_pend;
        M_AXI.WVALID  = w_pend;
        if ((!aw_pend || M_AXI.AWREADY) && (!w_pend || M_AXI.WREADY)) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        M_AXI.BREADY = 1'b1;
        if (M_AXI.BVALID) state_next = RSP;
      end
      RADDR: begin
        M_AXI.ARVALID = 1'b1;
        if (M_AXI.ARREADY) state_next = RDATA;
      end
      RDATA: begin
        M_AXI.RREADY = 1'b1;
        if (M_AXI.RVALID) state_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    M_AXI.AWADDR = M_AXI.AWVALID ? addr_q : '0;
    M_AXI.AWPROT = M_AXI.AWVALID ? C_PROT : 3'b000;
    M_AXI.WDATA  = M_AXI.WVALID ? wdata_q : '0;
    M_AXI.WSTRB  = M_AXI.WVALID ? wstrb_q : '0;
    M_AXI.ARADDR = M_AXI.ARVALID ? addr_q : '0;
    M_AXI.ARPROT = M_AXI.ARVALID ? C_PROT : 3'b000;
    rsp_we       = rsp_valid & we_q;
    rsp_rdata    = rsp_valid ? rdata_q : '0;
    rsp_resp     = rsp_valid ? resp_q : 2'b00;
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; only 32 supported.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 5, AXI byte-address width.
REQ-003 SHALL have parameter C_PROT, default 3'b000, value driven on AWPROT/ARPROT.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
- M_AXI_ACLK  in  1  clock; all logic on the rising edge.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 Command port:
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  byte strobes.
REQ-006 Response port:
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high.
- rsp_we  out  1  echo of cmd_we.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
REQ-007 AXI4-Lite master ports:
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in.
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in.
- M_AXI_BRESP/BVALID in, BREADY out.
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in.
- M_AXI_RDATA/RRESP/RVALID in, RREADY out.
- busy  out  1  high in every state except IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, WRITE, WRESP, RADDR, RDATA and RSP.
REQ-011 IDLE SHALL have cmd_ready=1 and all other outputs low.
- A command is accepted only in IDLE; one transaction is outstanding at a time.
- Accepting a command SHALL register addr, wdata, wstrb and we.
REQ-012 A write command SHALL go to WRITE, where AWVALID and WVALID are asserted together on the cycle after accept.
REQ-013 In WRITE, each VALID SHALL drop independently on the edge where its own READY is sampled high.
- AW and W may complete in any order or on the same cycle.
- WRITE SHALL go to WRESP once both have completed.
REQ-014 Once asserted, a VALID SHALL stay high, with address, data and strobes stable, until its handshake completes.
REQ-015 In WRESP, BREADY SHALL be 1.
- On BVALID: capture BRESP, set rsp_rdata=0, go to RSP.
REQ-016 A read command SHALL go to RADDR with ARVALID=1.
- On ARREADY: go to RDATA with RREADY=1.
- On RVALID: capture RDATA and RRESP, go to RSP.
REQ-017 In RSP, rsp_valid SHALL be 1 and the response fields SHALL be held stable.
- On rsp_ready: go to IDLE.
- The best-case write is 3 cycles from accept to rsp_valid, with zero-wait-state slave READYs.
- The best-case read is 3 cycles from accept to rsp_valid.
REQ-018 SLVERR or DECERR responses SHALL be forwarded unchanged in rsp_resp; no retry.
REQ-019 The block SHALL never assert AWVALID/WVALID and ARVALID at the same time.
REQ-020 BREADY and RREADY SHALL be low outside WRESP and RDATA respectively.
- BVALID or RVALID arriving in another state SHALL be ignored.

Reset
REQ-030 While M_AXI_ARESETN=0, all VALID and READY outputs SHALL be 0.
- rsp_valid=0, rsp_resp=0, rsp_rdata=0, cmd_ready=0, busy=0, FSM=IDLE.
- cmd_ready SHALL rise on the first clock edge after deassertion.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction immediately (asynchronous), with no response produced.

Verification
REQ-040 Write 0x00000002 to addr 0x00 with a zero-wait slave -> AW and W handshake on the same edge; rsp_resp=00 three cycles after accept.
REQ-041 Write addr 0x04 data 0x1; slave delays AWREADY by 3 cycles and asserts WREADY immediately -> WVALID drops first, AWVALID holds stable until its handshake, exactly one BREADY handshake.
REQ-042 Read addr 0x08 where the slave returns 0x00000001, RRESP=00 -> rsp_rdata=0x00000001, rsp_we=0; ARVALID never overlaps RREADY.
REQ-043 Write addr 0x0C data 0x3, then poll reads of 0x0C until bit31=1 (slave sets it after 10 cycles) -> each poll response is held until rsp_ready; the final rsp_rdata[31]=1.
REQ-044 Read where the slave returns RRESP=10 and RDATA=0xDEADBEEF -> rsp_resp=10, rsp_rdata=0xDEADBEEF, FSM back in IDLE after rsp_ready.
REQ-045 Assert reset while in WRESP with BVALID low -> all outputs 0 immediately; after release, a new write to 0x10 data 0xF completes normally with rsp_resp=00.
